// File: rtl/sha_nonce_dispatcher.sv
// Nonce dispatcher: runs double SHA-256 per nonce on one shared sha_core.
// Ports: job_* (job in/abort/done), hit_* (1-entry hit buffer),
//   hash_count (nonces checked), core_* (sha_core start/state/message/result/done).
module sha_nonce_dispatcher #(
    parameter int ZERO_BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         job_abort,
    output logic         job_done,
    output logic         hit_valid,
    input  logic         hit_ready,
    output logic [31:0]  hit_nonce,
    output logic [255:0] hit_hash,
    output logic [31:0]  hash_count,
    output logic         core_start,
    output logic [255:0] core_start_state,
    output logic [511:0] core_message,
    input  logic [255:0] core_result,
    input  logic         core_done
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Top ZERO_BITS bits set; 0 gives an empty mask (every nonce hits).
    localparam logic [31:0] HIT_MASK = ~(32'hffff_ffff >> ZERO_BITS);

    typedef enum logic [2:0] {
        IDLE, P1_START, P1_WAIT, P2_START, P2_WAIT, CHECK, HIT_HOLD, DRAIN
    } state_t;

    state_t        state, state_n;
    logic          start_cnt;
    logic [255:0]  mid_q;
    logic [95:0]   tail_q;
    logic [31:0]   nonce_q, nonce_n;
    logic [31:0]   end_q;
    logic [255:0]  hash2_q;
    logic [31:0]   swapped;
    logic          hit;
    logic          load_job, cap_h1, cap_h2, count, set_hit;
    logic          pop, drop, done_n, advance, enter_p1;

    assign swapped = {hash2_q[7:0], hash2_q[15:8],
                      hash2_q[23:16], hash2_q[31:24]};
    assign hit = (swapped & HIT_MASK) == 32'h0;
    assign enter_p1 = (state_n == P1_START) && (state != P1_START);

    always_comb begin
        state_n  = state;
        nonce_n  = nonce_q;
        load_job = 1'b0;
        cap_h1   = 1'b0;
        cap_h2   = 1'b0;
        count    = 1'b0;
        set_hit  = 1'b0;
        pop      = 1'b0;
        drop     = 1'b0;
        done_n   = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: if (job_valid && job_ready) begin
                load_job = 1'b1;
                nonce_n  = job_nonce_start;
                state_n  = P1_START;
            end
            P1_START: if (start_cnt) state_n = P1_WAIT;
            P1_WAIT: if (core_done) begin
                cap_h1  = 1'b1;
                state_n = P2_START;
            end
            P2_START: if (start_cnt) state_n = P2_WAIT;
            P2_WAIT: if (core_done) begin
                cap_h2  = 1'b1;
                state_n = CHECK;
            end
            CHECK: begin
                count = 1'b1;
                if (hit) begin
                    set_hit = 1'b1;
                    state_n = HIT_HOLD;
                end else begin
                    advance = 1'b1;
                end
            end
            HIT_HOLD: if (hit_ready) begin
                pop     = 1'b1;
                advance = 1'b1;
            end
            DRAIN: if (core_done) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (nonce_q == end_q) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end else begin
                nonce_n = nonce_q + 32'd1;
                state_n = P1_START;
            end
        end

        // DRAIN is already the abort path, so a repeated abort keeps waiting.
        // A pass finishing on the abort cycle leaves the core idle: no drain.
        if (job_abort && state != IDLE && state != DRAIN) begin
            drop    = 1'b1;
            cap_h1  = 1'b0;
            cap_h2  = 1'b0;
            set_hit = 1'b0;
            pop     = 1'b0;
            nonce_n = nonce_q;
            if ((state == P1_WAIT || state == P2_WAIT) && !core_done) begin
                done_n  = 1'b0;
                state_n = DRAIN;
            end else begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            start_cnt        <= 1'b0;
            job_ready        <= 1'b0;
            job_done         <= 1'b0;
            core_start       <= 1'b0;
            core_start_state <= '0;
            core_message     <= '0;
            mid_q            <= '0;
            tail_q           <= '0;
            nonce_q          <= '0;
            end_q            <= '0;
            hash2_q          <= '0;
            hash_count       <= '0;
            hit_valid        <= 1'b0;
            hit_nonce        <= '0;
            hit_hash         <= '0;
        end else begin
            state      <= state_n;
            start_cnt  <= (state_n == state) &&
                          (state == P1_START || state == P2_START);
            job_ready  <= (state_n == IDLE);
            job_done   <= done_n;
            core_start <= (state_n == P1_START) || (state_n == P2_START);
            nonce_q    <= nonce_n;
            if (load_job) begin
                mid_q  <= job_midstate;
                tail_q <= job_tail;
                end_q  <= job_nonce_end;
            end
            // State and message stay put until the pass result is captured.
            if (enter_p1) begin
                core_start_state <= load_job ? job_midstate : mid_q;
                core_message <= {load_job ? job_tail : tail_q, nonce_n,
                                 32'h80000000, 320'b0, 32'h00000280};
            end else if (cap_h1) begin
                core_start_state <= IV;
                core_message <= {core_result, 32'h80000000,
                                 192'b0, 32'h00000100};
            end
            if (cap_h2) hash2_q <= core_result;
            if (count) hash_count <= hash_count + 32'd1;
            if (set_hit) begin
                hit_valid <= 1'b1;
                hit_nonce <= nonce_q;
                hit_hash  <= hash2_q;
            end else if (pop || drop) begin
                hit_valid <= 1'b0;
            end
        end
    end

endmodule
